// File: rtl/axi_sram_pkg.sv
// Shared state type, response/enable constants and AXI channel widths for the AXI SRAM responder.
// AXI width macros default here; a project-wide AXI_define.svh compiled earlier overrides them.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_sram_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] WEB_IDLE  = 4'hF;
endpackage

// File: rtl/axi_sram_if.sv
// AXI4 bus bundle between the interconnect slave port and the SRAM responder.
interface axi_sram_if;
  logic [`AXI_IDS_BITS-1:0]  AWID;
  logic [`AXI_ADDR_BITS-1:0] AWADDR;
  logic [`AXI_LEN_BITS-1:0]  AWLEN;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE;
  logic [1:0]                AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [`AXI_DATA_BITS-1:0] WDATA;
  logic [`AXI_STRB_BITS-1:0] WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;
  logic [`AXI_IDS_BITS-1:0]  BID;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [`AXI_IDS_BITS-1:0]  ARID;
  logic [`AXI_ADDR_BITS-1:0] ARADDR;
  logic [`AXI_LEN_BITS-1:0]  ARLEN;
  logic [`AXI_SIZE_BITS-1:0] ARSIZE;
  logic [1:0]                ARBURST;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [`AXI_IDS_BITS-1:0]  RID;
  logic [`AXI_DATA_BITS-1:0] RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_burst_ctr.sv
// Beat counter and word-address incrementer for one AXI burst; wraps modulo 2^ADDR_W.
module axi_sram_burst_ctr #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = `AXI_LEN_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= load_addr;
      cnt_q <= '0;
      len_q <= load_len;
    end else if (step) begin
      addr  <= next_addr;
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  assign next_addr = addr + ADDR_W'(1);
  assign last      = (cnt_q == len_q);
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder mapping single-beat and burst transfers onto a single-port word SRAM macro.
// Optional AXI_SRAM_RD_PIPE_EN overlaps the next read access with the current R handshake.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  axi_sram_if.slave         axi,
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);
  state_e state_q, state_d;

  logic [`AXI_IDS_BITS-1:0] id_q;
  logic [31:0]              rdata_cap_p1;
  logic                     rd_first_p1;
  logic                     rd_issue;
  logic                     aw_hs;
  logic                     load, step, last;
  logic [ADDR_W-1:0]        addr, next_addr;
  logic                     unused_bits;

  axi_sram_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(`AXI_LEN_BITS)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .load_addr (aw_hs ? axi.AWADDR[ADDR_W+1:2] : axi.ARADDR[ADDR_W+1:2]),
    .load_len  (aw_hs ? axi.AWLEN : axi.ARLEN),
    .addr      (addr),
    .next_addr (next_addr),
    .last      (last)
  );

  // Outputs are forced idle while rst is high so an interrupted burst makes no further access.
  always_comb begin
    state_d     = state_q;
    axi.AWREADY = 1'b0;
    axi.ARREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RLAST   = 1'b0;
    axi.BVALID  = 1'b0;
    CEB         = 1'b1;
    WEB         = WEB_IDLE;
    A           = '0;
    DI          = '0;
    aw_hs       = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    rd_issue    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          axi.AWREADY = 1'b1;
          axi.ARREADY = ~axi.AWVALID;
          if (axi.AWVALID) begin
            aw_hs   = 1'b1;
            load    = 1'b1;
            state_d = WR_DATA;
          end else if (axi.ARVALID) begin
            load    = 1'b1;
            state_d = RD_REQ;
          end
        end
        RD_REQ: begin
          CEB      = 1'b0;
          A        = addr;
          rd_issue = 1'b1;
          state_d  = RD_DATA;
        end
        RD_DATA: begin
          axi.RVALID = 1'b1;
          axi.RLAST  = last;
          if (axi.RREADY) begin
            step = 1'b1;
            if (last) begin
              state_d = IDLE;
            end else begin
`ifdef AXI_SRAM_RD_PIPE_EN
              CEB      = 1'b0;
              A        = next_addr;
              rd_issue = 1'b1;
              state_d  = RD_DATA;
`else
              state_d  = RD_REQ;
`endif
            end
          end
        end
        WR_DATA: begin
          axi.WREADY = 1'b1;
          if (axi.WVALID) begin
            CEB  = 1'b0;
            WEB  = ~axi.WSTRB;
            DI   = axi.WDATA;
            A    = addr;
            step = 1'b1;
            if (last) state_d = WR_RESP;
          end
        end
        WR_RESP: begin
          axi.BVALID = 1'b1;
          if (axi.BREADY) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_first_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_first_p1 <= rd_issue;
    end
  end

  // ---- stage p1: DO is live only on the first R cycle; later cycles replay the capture ----
  always_ff @(posedge clk) begin
    if (load) id_q <= aw_hs ? axi.AWID : axi.ARID;
    if (rd_first_p1) rdata_cap_p1 <= DO;
  end

  assign axi.RDATA = !axi.RVALID ? '0 : (rd_first_p1 ? DO : rdata_cap_p1);
  assign axi.RID   = axi.RVALID ? id_q : '0;
  assign axi.BID   = axi.BVALID ? id_q : '0;
  assign axi.RRESP = RESP_OKAY;
  assign axi.BRESP = RESP_OKAY;

  assign unused_bits = ^{axi.AWSIZE, axi.AWBURST, axi.ARSIZE, axi.ARBURST, axi.WLAST,
                         axi.AWADDR[`AXI_ADDR_BITS-1:ADDR_W+2], axi.AWADDR[1:0],
                         axi.ARADDR[`AXI_ADDR_BITS-1:ADDR_W+2], axi.ARADDR[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed AXI traffic against a behavioural SRAM model.
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int ADDR_W = 14;
`ifdef AXI_SRAM_RD_PIPE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              CEB;
  logic [3:0]        WEB;
  logic [ADDR_W-1:0] A;
  logic [31:0]       DI;
  logic [31:0]       DO;

  axi_sram_if ax ();

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk (clk), .rst (rst), .axi (ax.slave),
    .CEB (CEB), .WEB (WEB), .A (A), .DI (DI), .DO (DO)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, per-byte active-low write enables
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_a;
  logic [31:0]       poke_d;
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    if (!CEB) begin
      if (WEB == 4'hF) DO <= mem[A];
      else for (int b = 0; b < 4; b++) if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  typedef struct packed {
    logic [31:0]              data;
    logic [`AXI_IDS_BITS-1:0] id;
    logic                     last;
  } rexp_t;

  rexp_t                    rq[$];
  logic [`AXI_IDS_BITS-1:0] bq[$];
  int                       r_hs_cyc[$];
  int                       b_hs_cyc = 0;
  int                       r_count = 0;

  rexp_t                    re;
  logic [`AXI_IDS_BITS-1:0] be;
  logic                     hold_v = 1'b0;
  logic [31:0]              hold_d;
  logic                     hold_l;

  // Monitor: pops the scoreboard on every handshake and checks payload stability under stall
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      check("ceb_in_rst", CEB, 1'b1);
    end else begin
      if (hold_v) begin
        check("rvalid_hold", ax.RVALID, 1'b1);
        check("rdata_hold", ax.RDATA, hold_d);
        check("rlast_hold", ax.RLAST, hold_l);
      end
      if (ax.RVALID && ax.RREADY) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          re = rq.pop_front();
          check("rdata", ax.RDATA, re.data);
          check("rid", ax.RID, re.id);
          check("rlast", ax.RLAST, re.last);
          check("rresp", ax.RRESP, RESP_OKAY);
          r_hs_cyc.push_back(cyc + 1);
          r_count++;
        end
      end
      hold_v = ax.RVALID && !ax.RREADY;
      hold_d = ax.RDATA;
      hold_l = ax.RLAST;
      if (ax.BVALID && ax.BREADY) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          be = bq.pop_front();
          check("bid", ax.BID, be);
          check("bresp", ax.BRESP, RESP_OKAY);
          b_hs_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    poke_a = ADDR_W'(a); poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       output int hs);
    ax.ARID = id; ax.ARADDR = addr; ax.ARLEN = len; ax.ARSIZE = 3'd2; ax.ARBURST = 2'b01;
    ax.ARVALID = 1'b1;
    hs = -1;
    for (int i = 0; i < 60 && hs < 0; i++) begin
      @(negedge clk);
      if (ax.ARREADY) begin @(posedge clk); #1; hs = cyc; end
    end
    ax.ARVALID = 1'b0;
    if (hs < 0) fail_now("ar_handshake");
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       output int hs);
    ax.AWID = id; ax.AWADDR = addr; ax.AWLEN = len; ax.AWSIZE = 3'd2; ax.AWBURST = 2'b01;
    ax.AWVALID = 1'b1;
    hs = -1;
    for (int i = 0; i < 60 && hs < 0; i++) begin
      @(negedge clk);
      if (ax.AWREADY) begin @(posedge clk); #1; hs = cyc; end
    end
    ax.AWVALID = 1'b0;
    if (hs < 0) fail_now("aw_handshake");
  endtask

  logic [31:0]       wd  [0:3];
  logic [3:0]        ws  [0:3];
  logic              w_ceb [0:3];
  logic [3:0]        w_web [0:3];
  logic [ADDR_W-1:0] w_a   [0:3];
  logic [31:0]       w_di  [0:3];

  task automatic do_w(input int n);
    int tries;
    for (int k = 0; k < n; k++) begin
      ax.WDATA = wd[k]; ax.WSTRB = ws[k]; ax.WLAST = (k == n - 1); ax.WVALID = 1'b1;
      tries = 0;
      do begin
        @(negedge clk);
        tries++;
      end while (!ax.WREADY && tries < 60);
      check("wready_immediate", tries, 1);
      w_ceb[k] = CEB; w_web[k] = WEB; w_a[k] = A; w_di[k] = DI;
      @(posedge clk); #1;
    end
    ax.WVALID = 1'b0; ax.WLAST = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((rq.size() != 0 || bq.size() != 0) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 200) fail_now("drain");
    @(posedge clk); #1;
  endtask

  int hs, hs2, hs_aw, base, n;

  initial begin
    ax.AWID = '0; ax.AWADDR = '0; ax.AWLEN = '0; ax.AWSIZE = '0; ax.AWBURST = '0; ax.AWVALID = 1'b0;
    ax.WDATA = '0; ax.WSTRB = '0; ax.WLAST = 1'b0; ax.WVALID = 1'b0; ax.BREADY = 1'b1;
    ax.ARID = '0; ax.ARADDR = '0; ax.ARLEN = '0; ax.ARSIZE = '0; ax.ARBURST = '0; ax.ARVALID = 1'b0;
    ax.RREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", ax.AWREADY, 0); check("rst_arready", ax.ARREADY, 0);
    check("rst_wready", ax.WREADY, 0);   check("rst_rvalid", ax.RVALID, 0);
    check("rst_bvalid", ax.BVALID, 0);   check("rst_rlast", ax.RLAST, 0);
    check("rst_rid", ax.RID, 0);         check("rst_bid", ax.BID, 0);
    check("rst_rdata", ax.RDATA, 0);     check("rst_rresp", ax.RRESP, 0);
    check("rst_bresp", ax.BRESP, 0);     check("rst_ceb", CEB, 1);
    check("rst_web", WEB, 4'hF);         check("rst_a", A, 0);
    check("rst_di", DI, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read with t+2 latency
    poke(32'h10, 32'hDEADBEEF);
    r_hs_cyc.delete();
    rq.push_back('{data: 32'hDEADBEEF, id: 8'h25, last: 1'b1});
    do_ar(8'h25, 32'h40, 4'd0, hs);
    @(negedge clk);
    check("rdreq_rvalid", ax.RVALID, 0); check("rdreq_ceb", CEB, 0);
    check("rdreq_a", A, 14'h10);         check("rdreq_web", WEB, 4'hF);
    @(negedge clk);
    check("rd_rvalid", ax.RVALID, 1);
    wait_idle();
    if (r_hs_cyc.size() > 0) check("rd_latency", r_hs_cyc[0], hs + 2);
    else fail_now("rd_latency");

    // Read burst with a 3-cycle stall on beat 1
    for (int k = 0; k < 4; k++) poke(32'h40 + k, 32'hA0B0_0000 + k);
    r_hs_cyc.delete();
    for (int k = 0; k < 4; k++) rq.push_back('{data: 32'hA0B0_0000 + k, id: 8'h11, last: (k == 3)});
    ax.RREADY = 1'b0;
    do_ar(8'h11, 32'h100, 4'd3, hs);
    n = 0;
    do begin @(negedge clk); n++; end while (!ax.RVALID && n < 20);
    check("burst_first_rvalid", ax.RVALID, 1);
    repeat (3) @(posedge clk);
    #1 ax.RREADY = 1'b1;
    wait_idle();
    if (r_hs_cyc.size() == 4)
      for (int k = 1; k < 4; k++) check("stall_gap", r_hs_cyc[k] - r_hs_cyc[k-1], GAP);
    else fail_now("stall_beats");

    // Same burst with RREADY high: beat arrival pattern
    r_hs_cyc.delete();
    for (int k = 0; k < 4; k++) rq.push_back('{data: 32'hA0B0_0000 + k, id: 8'h12, last: (k == 3)});
    do_ar(8'h12, 32'h100, 4'd3, hs);
    wait_idle();
    if (r_hs_cyc.size() == 4)
      for (int k = 0; k < 4; k++) check("burst_timing", r_hs_cyc[k], hs + 2 + k * GAP);
    else fail_now("burst_beats");

    // Partial write with byte strobes
    poke(2, 32'hAABBCCDD);
    bq.push_back(8'h3C);
    do_aw(8'h3C, 32'h8, 4'd0, hs_aw);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_w(1);
    check("pw_web", w_web[0], 4'b1010); check("pw_a", w_a[0], 2);
    check("pw_ceb", w_ceb[0], 0);       check("pw_di", w_di[0], 32'h11223344);
    @(negedge clk);
    check("pw_bvalid", ax.BVALID, 1);
    wait_idle();
    check("pw_mem", mem[2], 32'hAA22CC44);

    // Simultaneous AW/AR: write wins, read served after B
    bq.push_back(8'h51);
    rq.push_back('{data: 32'hDEADBEEF, id: 8'h52, last: 1'b1});
    wd[0] = 32'h5555AAAA; ws[0] = 4'hF;
    fork
      begin do_aw(8'h51, 32'h20, 4'd0, hs_aw); do_w(1); end
      begin do_ar(8'h52, 32'h40, 4'd0, hs2); end
      begin
        @(negedge clk);
        check("sim_awready", ax.AWREADY, 1);
        check("sim_arready", ax.ARREADY, 0);
      end
    join
    wait_idle();
    check("sim_ar_after_b", (hs2 > b_hs_cyc), 1);
    check("sim_mem", mem[8], 32'h5555AAAA);

    // Wrap past the top word; high address bits ignored
    bq.push_back(8'h66);
    do_aw(8'h66, 32'h1234_FFFC, 4'd1, hs_aw);
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_w(2);
    check("wrap_a0", w_a[0], 14'h3FFF); check("wrap_a1", w_a[1], 0);
    wait_idle();
    check("wrap_mem_top", mem[16383], 32'hCAFE0001);
    check("wrap_mem_0", mem[0], 32'hCAFE0002);
    rq.push_back('{data: 32'hCAFE0001, id: 8'h67, last: 1'b0});
    rq.push_back('{data: 32'hCAFE0002, id: 8'h67, last: 1'b1});
    do_ar(8'h67, 32'h5550_FFFC, 4'd1, hs);
    wait_idle();

    // Reset during beat 2 of a 4-beat read
    for (int k = 0; k < 4; k++) poke(32'h80 + k, 32'hBEEF_0000 + k);
    rq.push_back('{data: 32'hBEEF_0000, id: 8'h77, last: 1'b0});
    base = r_count;
    do_ar(8'h77, 32'h200, 4'd3, hs);
    n = 0;
    while (r_count == base && n < 20) begin @(posedge clk); #1; n++; end
    ax.RREADY = 1'b0;
    if (n >= 20) fail_now("rst_beat1");
    n = 0;
    do begin @(negedge clk); n++; end while (!ax.RVALID && n < 20);
    check("rst_beat2_present", ax.RVALID, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", ax.RVALID, 0); check("midrst_ceb", CEB, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_rvalid", ax.RVALID, 0); check("postrst_ceb", CEB, 1);
    check("postrst_awready", ax.AWREADY, 1); check("postrst_arready", ax.ARREADY, 1);
    ax.RREADY = 1'b1;
    rq.push_back('{data: 32'hBEEF_0001, id: 8'h78, last: 1'b1});
    do_ar(8'h78, 32'h204, 4'd0, hs);
    wait_idle();

    check("rq_empty", rq.size(), 0);
    check("bq_empty", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
